m_uart_loader: RTL and testbench
================================

Name: m_uart_loader

Overview:
- Program loader and the write-side counterpart of the processor's instruction fetch.
- Receives a program image over a UART serial line and writes it word by word into the 4K-word memory (12-bit word address, 32-bit data, one-cycle write enable).
- Holds the processor in reset via r_busy until the image is fully written.
- Sits in m_main between the board RX pin and the imem write port.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- ADDR_W, 12, memory word-address width.
- MAX_WORDS, 4096, largest accepted image size in words.

Ports:
- w_clk  input  1  system clock; all state changes on posedge.
- w_rst_n  input  1  reset, asynchronous, active-low.
- w_rxd  input  1  UART serial input, idle high, asynchronous to w_clk.
- r_addr  output  ADDR_W  memory word address of the current write.
- r_din  output  32  memory write data.
- r_we  output  1  memory write enable, one-cycle pulse per word.
- r_busy  output  1  high while loading; processor reset is w_rst | r_busy.
- r_done  output  1  image fully written; sticky.
- r_err  output  1  framing or length error; sticky.
- r_nwords  output  ADDR_W+1  word count taken from the header.

Behaviour:
- Reset (w_rst_n=0, asynchronous):
  - r_addr=0, r_din=0, r_we=0, r_busy=1, r_done=0, r_err=0, r_nwords=0.
  - FSM enters S_HDR; RX engine goes idle; both synchroniser flops are set to 1.
  - Reset mid-byte or mid-image aborts everything. The partial image already in memory is left as is.
- RX engine:
  - 2-flop synchroniser on w_rxd.
  - Start is detected when the synchronised line is 0 while the engine is idle.
  - Resample at CLKS_PER_BIT/2 (integer division). If the line is 1 there, it was a glitch: return to idle, no byte.
  - Then sample every CLKS_PER_BIT cycles: 8 data bits, LSB first, then the stop bit.
  - Stop bit = 1: one-cycle byte-valid strobe with the byte, raised the cycle after the stop sample.
  - Stop bit = 0: framing error, r_err=1, FSM goes to S_ERR.
- Byte FSM, with a 2-bit byte index and a 32-bit shift register, big-endian (first byte → bits 31:24):
  - S_HDR: collects 4 bytes into the count N, then:
    - N > MAX_WORDS → r_err=1, S_ERR.
    - N == 0 → r_nwords=0, r_done=1, r_busy=0, S_DONE.
    - Otherwise → r_nwords=N[ADDR_W:0], r_addr=0, S_DATA.
  - S_DATA: on the 4th byte of each word:
    - The next cycle gives r_din=word, r_we=1 for exactly one cycle, at the current r_addr.
    - The cycle after the pulse, r_addr increments.
    - After the pulse for word N-1: r_addr stays at N-1, r_done=1 and r_busy=0 in the same cycle, S_DONE.
  - S_DONE: all further bytes are ignored and r_we stays 0. Exited only by reset.
  - S_ERR: r_busy stays 1, r_we stays 0, all input is ignored. Exited only by reset.
- Write latency: r_we rises exactly 2 cycles after the stop-bit sample of a word's last byte.
- Wrap: N == MAX_WORDS writes addresses 0..MAX_WORDS-1. r_addr never wraps to 0 because it stops at N-1.
- r_din holds the last written word between pulses. r_we is never high in two consecutive cycles.

Test Plan:
- CLKS_PER_BIT=8. Send header 00 00 00 02, then 12 34 56 78, then DE AD BE EF.
  - Required: r_we pulses twice, (addr 0, din 0x12345678) then (addr 1, din 0xDEADBEEF).
  - Required: r_done=1, r_busy=0, r_nwords=2, r_err=0.
- Header 00 00 00 00 → r_done=1 and r_busy=0 immediately after the 4th header byte; no r_we pulse.
- Header 00 00 10 01 (4097) → r_err=1, r_busy=1, no r_we; later bytes are ignored.
- Byte 0x55 with its stop bit forced to 0 during a data word → r_err=1; no further r_we even if valid bytes follow.
- A 2-cycle low glitch on idle w_rxd → no byte is received and the FSM state is unchanged. Then a 0xA5 byte is received correctly.
- w_rst_n pulled low for 1 cycle midway through the 2nd data word → all outputs return to reset values at once. A fresh 1-word image (00 00 00 01, CA FE BA BE) then writes addr 0 = 0xCAFEBABE.

Source files
------------

// File: rtl/m_uart_loader.sv
// m_uart_loader
// Receives a program image over a UART line and writes it word by word into
// instruction memory. The processor is held in reset (via r_busy) until the
// whole image has been written.
//
// Image format: 4-byte big-endian word count N, followed by N 32-bit words,
// each sent big-endian (first byte lands in bits 31:24).
//
// Ports:
//   w_clk     system clock, all state changes on posedge
//   w_rst_n   asynchronous active-low reset
//   w_rxd     UART serial input (idle high, asynchronous to w_clk)
//   r_addr    memory word address of the current write
//   r_din     memory write data (holds the last written word)
//   r_we      one-cycle write strobe per word
//   r_busy    high while loading, or after an error
//   r_done    image fully written (sticky until reset)
//   r_err     framing or length error (sticky until reset)
//   r_nwords  word count taken from the header
module m_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int MAX_WORDS    = 4096
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_din,
  output logic              r_we,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err,
  output logic [ADDR_W:0]   r_nwords
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE, S_ERR} ld_state_t;

  // Receiver state
  logic             sync1_q, sync2_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Loader state
  ld_state_t        state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ADDR_W:0]  nwords_q, nwords_d;
  logic [31:0]      word_next;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= w_rxd;
      sync2_q <= sync1_q;
    end
  end

  // Receiver: start is re-checked at mid-bit to reject glitches, then every
  // bit is sampled one bit period later, LSB first, ending with the stop bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d      = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d        = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = sync2_q;
          frame_err_d  = !sync2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word_next = {word_q[23:0], rx_shift_q};

  // Loader FSM: header collects the count, data bytes are packed into words
  // and written; the address advances in the cycle after each write pulse.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    nwords_d   = nwords_q;
    case (state_q)
      S_HDR: begin
        if (frame_err_q) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (byte_valid_q) begin
          word_d     = word_next;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            if (word_next > 32'(MAX_WORDS)) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else if (word_next == 32'd0) begin
              nwords_d = '0;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              state_d  = S_DONE;
            end else begin
              nwords_d = word_next[ADDR_W:0];
              addr_d   = '0;
              state_d  = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (frame_err_q) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (byte_valid_q) begin
          word_d     = word_next;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            din_d = word_next;
            we_d  = 1'b1;
          end
        end else if (we_q) begin
          // Last word stops the address at N-1 instead of wrapping.
          if ({1'b0, addr_q} == nwords_q - (ADDR_W + 1)'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_HDR;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nwords_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nwords_q   <= nwords_d;
    end
  end

  assign r_addr   = addr_q;
  assign r_din    = din_q;
  assign r_we     = we_q;
  assign r_busy   = busy_q;
  assign r_done   = done_q;
  assign r_err    = err_q;
  assign r_nwords = nwords_q;

endmodule

// File: tb/tb_m_uart_loader.sv
// tb_m_uart_loader
// Directed bench for m_uart_loader with a short bit period. Write pulses are
// recorded by a monitor and compared against hand-computed images.
module tb_m_uart_loader;

  localparam int CPB = 8;

  logic        w_clk;
  logic        w_rst_n;
  logic        w_rxd;
  logic [11:0] r_addr;
  logic [31:0] r_din;
  logic        r_we;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [12:0] r_nwords;

  int checks = 0;
  int failures = 0;
  int weCount = 0;
  int weBase = 0;
  int backToBack = 0;
  logic prevWe = 1'b0;
  logic [11:0] weAddr [16];
  logic [31:0] weDin [16];

  m_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(12),
    .MAX_WORDS(4096)
  ) dut (
    .w_clk(w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd(w_rxd),
    .r_addr(r_addr),
    .r_din(r_din),
    .r_we(r_we),
    .r_busy(r_busy),
    .r_done(r_done),
    .r_err(r_err),
    .r_nwords(r_nwords)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Records every write pulse and flags any two adjacent pulses.
  always @(negedge w_clk) begin
    if (r_we === 1'b1) begin
      if (weCount < 16) begin
        weAddr[weCount] = r_addr;
        weDin[weCount] = r_din;
      end
      weCount = weCount + 1;
      if (prevWe) backToBack = backToBack + 1;
    end
    prevWe = (r_we === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one UART frame, then one idle bit period.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    @(negedge w_clk);
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (CPB) @(negedge w_clk);
    end
    w_rxd = stopBit;
    repeat (CPB) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24], 1'b1);
    applyStimulus(w[23:16], 1'b1);
    applyStimulus(w[15:8], 1'b1);
    applyStimulus(w[7:0], 1'b1);
  endtask

  task automatic doReset();
    @(negedge w_clk);
    w_rst_n = 1'b0;
    repeat (2) @(negedge w_clk);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    weBase = weCount;
  endtask

  task automatic glitch();
    @(negedge w_clk);
    w_rxd = 1'b0;
    repeat (2) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (20) @(negedge w_clk);
  endtask

  initial begin
    w_rst_n = 1'b0;
    w_rxd = 1'b1;
    repeat (3) @(negedge w_clk);
    checkOutput("rst_addr", 32'(r_addr), 32'd0);
    checkOutput("rst_din", r_din, 32'd0);
    checkOutput("rst_we", 32'(r_we), 32'd0);
    checkOutput("rst_busy", 32'(r_busy), 32'd1);
    checkOutput("rst_done", 32'(r_done), 32'd0);
    checkOutput("rst_err", 32'(r_err), 32'd0);
    checkOutput("rst_nwords", 32'(r_nwords), 32'd0);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    weBase = weCount;

    // Two-word image
    sendWord(32'h0000_0002);
    checkOutput("img2_busy_mid", 32'(r_busy), 32'd1);
    checkOutput("img2_nwords", 32'(r_nwords), 32'd2);
    sendWord(32'h1234_5678);
    sendWord(32'hDEAD_BEEF);
    repeat (4) @(negedge w_clk);
    checkOutput("img2_wecount", 32'(weCount - weBase), 32'd2);
    checkOutput("img2_addr0", 32'(weAddr[weBase]), 32'd0);
    checkOutput("img2_din0", weDin[weBase], 32'h1234_5678);
    checkOutput("img2_addr1", 32'(weAddr[weBase + 1]), 32'd1);
    checkOutput("img2_din1", weDin[weBase + 1], 32'hDEAD_BEEF);
    checkOutput("img2_done", 32'(r_done), 32'd1);
    checkOutput("img2_busy", 32'(r_busy), 32'd0);
    checkOutput("img2_err", 32'(r_err), 32'd0);
    checkOutput("img2_addr_hold", 32'(r_addr), 32'd1);
    checkOutput("img2_din_hold", r_din, 32'hDEAD_BEEF);
    // Extra bytes after completion are ignored
    sendWord(32'h0102_0304);
    checkOutput("img2_ignored_we", 32'(weCount - weBase), 32'd2);

    // Empty image
    doReset();
    sendWord(32'h0000_0000);
    checkOutput("zero_done", 32'(r_done), 32'd1);
    checkOutput("zero_busy", 32'(r_busy), 32'd0);
    checkOutput("zero_nwords", 32'(r_nwords), 32'd0);
    checkOutput("zero_we", 32'(weCount - weBase), 32'd0);

    // Largest legal count is accepted
    doReset();
    sendWord(32'h0000_1000);
    checkOutput("max_nwords", 32'(r_nwords), 32'h1000);
    checkOutput("max_err", 32'(r_err), 32'd0);
    checkOutput("max_busy", 32'(r_busy), 32'd1);

    // Oversized count
    doReset();
    sendWord(32'h0000_1001);
    checkOutput("big_err", 32'(r_err), 32'd1);
    checkOutput("big_busy", 32'(r_busy), 32'd1);
    sendWord(32'h1122_3344);
    sendWord(32'h5566_7788);
    checkOutput("big_we", 32'(weCount - weBase), 32'd0);
    checkOutput("big_done", 32'(r_done), 32'd0);

    // Framing error inside a data word
    doReset();
    sendWord(32'h0000_0002);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h55, 1'b0);
    checkOutput("frame_err", 32'(r_err), 32'd1);
    sendWord(32'h3344_5566);
    sendWord(32'h7788_99AA);
    checkOutput("frame_we", 32'(weCount - weBase), 32'd0);
    checkOutput("frame_busy", 32'(r_busy), 32'd1);
    checkOutput("frame_done", 32'(r_done), 32'd0);

    // Glitches on the idle line must not produce bytes
    doReset();
    glitch();
    sendWord(32'h0000_0001);
    checkOutput("glitch_nwords", 32'(r_nwords), 32'd1);
    glitch();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    glitch();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    repeat (4) @(negedge w_clk);
    checkOutput("glitch_wecount", 32'(weCount - weBase), 32'd1);
    checkOutput("glitch_din", weDin[weBase], 32'h0000_00A5);
    checkOutput("glitch_done", 32'(r_done), 32'd1);

    // Reset in the middle of the second data word
    doReset();
    sendWord(32'h0000_0002);
    sendWord(32'h1122_3344);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h66, 1'b1);
    checkOutput("mid_addr_before", 32'(r_addr), 32'd1);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_addr", 32'(r_addr), 32'd0);
    checkOutput("mid_rst_din", r_din, 32'd0);
    checkOutput("mid_rst_busy", 32'(r_busy), 32'd1);
    checkOutput("mid_rst_nwords", 32'(r_nwords), 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    weBase = weCount;
    sendWord(32'h0000_0001);
    sendWord(32'hCAFE_BABE);
    repeat (4) @(negedge w_clk);
    checkOutput("fresh_wecount", 32'(weCount - weBase), 32'd1);
    checkOutput("fresh_addr0", 32'(weAddr[weBase]), 32'd0);
    checkOutput("fresh_din0", weDin[weBase], 32'hCAFE_BABE);
    checkOutput("fresh_done", 32'(r_done), 32'd1);
    checkOutput("fresh_busy", 32'(r_busy), 32'd0);

    checkOutput("we_back_to_back", 32'(backToBack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
